fpga_hdl_demo: RTL and testbench
================================

Name: fpga_hdl_demo

Overview:
Top-level Tiny Tapeout demo block: a single-digit counter shown on a seven-segment display. A programmable prescaler divides the system clock into count ticks. The digit steps up or down in decimal (0-9) or hex (0-F), and a decimal point blinks once per tick. The block connects directly to the tile's ui_in/uo_out pins; all-zero inputs give the default free-running decimal up-count.

Parameters:
DIVIDER, 10_000_000, base prescaler period in clk cycles (1 tick/s at 10 MHz); must be >= 1; benches override to a small value.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset; synchronous, active-high
ui_in  input  8  controls: [0] pause, [1] count down, [2] hex mode, [3] synchronous clear, [7:4] speed select
uo_out  output  8  [6:0] segments a..g (bit0=a ... bit6=g), active-high; [7] decimal point, active-high

Behaviour:
- Priority per edge: rst > clear (ui_in[3]) > pause (ui_in[0]) > normal count.
- rst=1 at an edge: prescaler=0, digit=0, dp=0, so uo_out=0x3F the cycle after.
- clear=1 (rst=0): same register values as reset; held while asserted.
- Effective period P = max(DIVIDER >> ui_in[7:4], 1); ui_in[7:4]=0 gives P=DIVIDER.
- Prescaler (32-bit):
  - Pause=1: prescaler holds, no ticks.
  - Otherwise, if prescaler >= P-1 (>= covers a speed change that shrinks P), assert the tick this cycle and load 0; else increment.
- On tick:
  - dp toggles.
  - Digit updates, with max = 15 if ui_in[2]=1, else 9.
  - Up (ui_in[1]=0): digit >= max -> 0, else digit+1.
  - Down: digit = 0 or digit > max -> max, else digit-1.
- Latency: digit and dp change on the edge where prescaler==P-1. With ui_in=0 after reset, the first change is on the P-th rising edge after rst falls.
- Decoder: combinational from the registered digit, no extra latency.
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07
  - 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71
- Leaving hex mode with digit > 9: the glyph holds until the next tick, then up goes to 0 and down goes to 9.
- Mode, direction or speed changes take effect at the next edge; no glitch beyond that.
- Reset mid-count discards the prescaler phase; counting restarts from 0.
- No X on outputs after the first reset edge.

Test Plan:
1. DIVIDER=4, rst=1 for 2 cycles, ui_in=0 -> uo_out=0x3F, held while rst=1.
2. Release rst, ui_in=0 -> uo_out[6:0] steps every 4 clocks through 0x06,5B,4F,66,6D,7D,07,7F,6F then 0x3F at clock 40. First change is at the 4th edge; uo_out[7] toggles each step.
3. ui_in=0x04 (hex) from reset -> after 0x6F the sequence continues 0x77,7C,39,5E,79,71, then wraps to 0x3F at clock 64.
4. ui_in=0x02 (down) from reset -> first tick gives 0x6F, then 0x7F, 0x07. With hex also set (0x06), the first tick gives 0x71.
5. Count to 3 (0x4F), set ui_in=0x01 for 20 clocks -> uo_out frozen incl. dp. Release -> next step after the remaining prescaler cycles. ui_in=0x08 for 1 cycle -> 0x3F.
6. Assert rst for 1 cycle mid-period at digit 5 -> 0x3F next cycle; after release, first step exactly 4 clocks later. ui_in[7:4]=1 with DIVIDER=4 -> steps every 2 clocks.

Source files
------------

// File: rtl/fpga_hdl_demo_if.sv
// Pin bundle for the Tiny Tapeout tile: control inputs and display outputs.
// The tile side drives ui_in and reads uo_out.
interface fpga_hdl_demo_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;

    modport master (output ui_in, input uo_out);
    modport slave  (input ui_in, output uo_out);
endinterface

// File: rtl/fpga_hdl_demo.sv
// Single-digit up/down decimal/hex counter on a seven-segment display,
// stepped by a programmable prescaler; the decimal point blinks per tick.
module fpga_hdl_demo #(
    parameter int unsigned DIVIDER = 10_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    fpga_hdl_demo_if.slave        io
);

    localparam logic [31:0] P_DIV = 32'(DIVIDER);

    logic [31:0] r_presc;
    logic [3:0]  r_digit;
    logic        r_dp;

    logic        w_pause;
    logic        w_down;
    logic        w_hex;
    logic        w_clear;
    logic [3:0]  w_speed;
    logic [31:0] w_shift;
    logic [31:0] w_last;
    logic        w_tick;
    logic [3:0]  w_max;
    logic [3:0]  w_next;
    logic [6:0]  w_seg;

    assign w_pause = io.ui_in[0];
    assign w_down  = io.ui_in[1];
    assign w_hex   = io.ui_in[2];
    assign w_clear = io.ui_in[3];
    assign w_speed = io.ui_in[7:4];

    // Period never drops below one cycle, even for large speed shifts.
    assign w_shift = P_DIV >> w_speed;
    assign w_last  = (w_shift == 32'd0) ? 32'd0 : w_shift - 32'd1;
    // >= lets a shrinking period wrap immediately instead of overflowing.
    assign w_tick  = !w_pause && (r_presc >= w_last);
    assign w_max   = w_hex ? 4'd15 : 4'd9;

    always_comb begin
        w_next = r_digit;
        if (w_down) begin
            if (r_digit == 4'd0 || r_digit > w_max)
                w_next = w_max;
            else
                w_next = r_digit - 4'd1;
        end else begin
            if (r_digit >= w_max)
                w_next = 4'd0;
            else
                w_next = r_digit + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_presc <= 32'd0;
            r_digit <= 4'd0;
            r_dp    <= 1'b0;
        end else if (!w_pause) begin
            if (w_tick) begin
                r_presc <= 32'd0;
                r_digit <= w_next;
                r_dp    <= !r_dp;
            end else begin
                r_presc <= r_presc + 32'd1;
            end
        end
    end

    always_comb begin
        w_seg = 7'h00;
        unique case (r_digit)
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            4'hF: w_seg = 7'h71;
        endcase
    end

    assign io.uo_out = {r_dp, w_seg};

endmodule

// File: tb/tb_fpga_hdl_demo.sv
// Directed bench for fpga_hdl_demo with DIVIDER=4.
// Inputs change 1ns after a rising edge; outputs sampled there too.
module tb_fpga_hdl_demo;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    fpga_hdl_demo_if bus ();

    fpga_hdl_demo #(.DIVIDER(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] glyph(input int d, input logic dp);
        logic [6:0] s;
        case (d)
            0:  s = 7'h3F;
            1:  s = 7'h06;
            2:  s = 7'h5B;
            3:  s = 7'h4F;
            4:  s = 7'h66;
            5:  s = 7'h6D;
            6:  s = 7'h7D;
            7:  s = 7'h07;
            8:  s = 7'h7F;
            9:  s = 7'h6F;
            10: s = 7'h77;
            11: s = 7'h7C;
            12: s = 7'h39;
            13: s = 7'h5E;
            14: s = 7'h79;
            default: s = 7'h71;
        endcase
        return {dp, s};
    endfunction

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h want 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] ui);
        rst = 1'b1;
        bus.ui_in = ui;
        tick(1);
        check("rst1", bus.uo_out, 8'h3F);
        tick(1);
        check("rst2", bus.uo_out, 8'h3F);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.ui_in = 8'h00;

        // decimal up: first step on 4th edge, wrap at clock 40
        do_reset(8'h00);
        tick(3);
        check("pre_first", bus.uo_out, 8'h3F);
        tick(1);
        check("first", bus.uo_out, glyph(1, 1'b1));
        for (int k = 2; k <= 10; k++) begin
            tick(4);
            check($sformatf("dec%0d", k), bus.uo_out,
                  glyph(k % 10, 1'(k & 1)));
        end

        // hex up, wrap at clock 64
        do_reset(8'h04);
        for (int k = 1; k <= 16; k++) begin
            tick(4);
            check($sformatf("hex%0d", k), bus.uo_out,
                  glyph(k % 16, 1'(k & 1)));
        end

        // decimal down
        do_reset(8'h02);
        tick(4);
        check("dn9", bus.uo_out, glyph(9, 1'b1));
        tick(4);
        check("dn8", bus.uo_out, glyph(8, 1'b0));
        tick(4);
        check("dn7", bus.uo_out, glyph(7, 1'b1));

        // hex down
        do_reset(8'h06);
        tick(4);
        check("hdnF", bus.uo_out, glyph(15, 1'b1));

        // pause, resume, clear
        do_reset(8'h00);
        tick(12);
        check("at3", bus.uo_out, glyph(3, 1'b1));
        tick(2);
        bus.ui_in = 8'h01;
        tick(20);
        check("paused", bus.uo_out, glyph(3, 1'b1));
        bus.ui_in = 8'h00;
        tick(1);
        check("resume_hold", bus.uo_out, glyph(3, 1'b1));
        tick(1);
        check("resume_step", bus.uo_out, glyph(4, 1'b0));
        bus.ui_in = 8'h08;
        tick(1);
        check("clear", bus.uo_out, 8'h3F);
        bus.ui_in = 8'h00;

        // reset mid-period discards phase
        do_reset(8'h00);
        tick(20);
        check("at5", bus.uo_out, glyph(5, 1'b1));
        tick(2);
        rst = 1'b1;
        tick(1);
        check("midrst", bus.uo_out, 8'h3F);
        rst = 1'b0;
        tick(3);
        check("midrst_hold", bus.uo_out, 8'h3F);
        tick(1);
        check("midrst_step", bus.uo_out, glyph(1, 1'b1));

        // speed 1 halves the period
        do_reset(8'h10);
        tick(1);
        check("spd_hold", bus.uo_out, 8'h3F);
        tick(1);
        check("spd1", bus.uo_out, glyph(1, 1'b1));
        tick(2);
        check("spd2", bus.uo_out, glyph(2, 1'b0));

        // leave hex at A, counting up
        do_reset(8'h04);
        tick(40);
        check("hexA", bus.uo_out, glyph(10, 1'b0));
        bus.ui_in = 8'h00;
        tick(3);
        check("A_hold", bus.uo_out, glyph(10, 1'b0));
        tick(1);
        check("A_up", bus.uo_out, glyph(0, 1'b1));

        // leave hex at A, counting down
        do_reset(8'h04);
        tick(40);
        bus.ui_in = 8'h02;
        tick(4);
        check("A_dn", bus.uo_out, glyph(9, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
